// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a
// saturating bubble counter. Priority per edge: freeze > flush > lu_stall > load.
module id_ex_stage #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              freeze,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [1:0]        id_RegDst,
  input  logic              id_regWr,
  input  logic              id_memRead,
  input  logic              id_memWr,
  input  logic [3:0]        id_aluop,
  input  logic [WORD_W-1:0] id_rdat1,
  input  logic [WORD_W-1:0] id_rdat2,
  input  logic [WORD_W-1:0] id_imm,
  input  logic [WORD_W-1:0] id_pc4,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [1:0]        ex_RegDst,
  output logic              exRegWr,
  output logic              exMemRead,
  output logic              exMemWr,
  output logic [3:0]        ex_aluop,
  output logic [WORD_W-1:0] ex_rdat1,
  output logic [WORD_W-1:0] ex_rdat2,
  output logic [WORD_W-1:0] ex_imm,
  output logic [WORD_W-1:0] ex_pc4,
  output logic              lu_stall,
  output logic [15:0]       bubble_cnt
);

  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic rs_hit;
  logic rt_hit;
  logic bubble;
  logic load;

  // Load in EX whose destination is a source of the instruction in ID; r0 never hazards.
  assign rs_hit   = (ex_rt == id_rs);
  assign rt_hit   = (ex_rt == id_rt);
  assign lu_stall = ex_valid & exMemRead & id_valid & ~flush &
                    (ex_rt != 5'd0) & (rs_hit | rt_hit);

  // Action select for this edge; freeze overrides everything.
  assign bubble = ~freeze & (flush | lu_stall);
  assign load   = ~freeze & ~flush & ~lu_stall;

  // Control and register-number fields: cleared on bubble, loaded on load.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_valid  <= 1'b0;
      ex_rs     <= 5'd0;
      ex_rt     <= 5'd0;
      ex_rd     <= 5'd0;
      ex_RegDst <= 2'd0;
      exRegWr   <= 1'b0;
      exMemRead <= 1'b0;
      exMemWr   <= 1'b0;
      ex_aluop  <= 4'd0;
    end else if (bubble) begin
      ex_valid  <= 1'b0;
      ex_rs     <= 5'd0;
      ex_rt     <= 5'd0;
      ex_rd     <= 5'd0;
      ex_RegDst <= 2'd0;
      exRegWr   <= 1'b0;
      exMemRead <= 1'b0;
      exMemWr   <= 1'b0;
      ex_aluop  <= 4'd0;
    end else if (load) begin
      ex_valid  <= id_valid;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
      ex_RegDst <= id_RegDst;
      exRegWr   <= id_regWr;
      exMemRead <= id_memRead;
      exMemWr   <= id_memWr;
      ex_aluop  <= id_aluop;
    end
  end

  // Datapath fields only move on a load; a bubble leaves them as they were.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_rdat1 <= '0;
      ex_rdat2 <= '0;
      ex_imm   <= '0;
      ex_pc4   <= '0;
    end else if (load) begin
      ex_rdat1 <= id_rdat1;
      ex_rdat2 <= id_rdat2;
      ex_imm   <= id_imm;
      ex_pc4   <= id_pc4;
    end
  end

  // Count load-use bubbles only (not flushes), saturating at all-ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bubble_cnt <= '0;
    end else if (!freeze && lu_stall && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter WORD_W, default 32, datapath word width.
REQ-002 SHALL have ports, one per line:
  CLK  in  1  system clock, rising edge
  nRST  in  1  asynchronous active-low reset
  freeze  in  1  memory-wait stall, holds whole stage
  flush  in  1  branch/jump resolved in EX, kill incoming ID instruction
  id_valid  in  1  ID holds a real instruction
  id_rs, id_rt, id_rd  in  5 each  decoded register numbers
  id_RegDst  in  2  destination select
  id_regWr, id_memRead, id_memWr  in  1 each  decoded controls
  id_aluop  in  4  ALU operation
  id_rdat1, id_rdat2, id_imm, id_pc4  in  WORD_W each  operands, extended immediate, PC+4
  ex_valid  out  1  EX holds a real instruction
  ex_rs, ex_rt, ex_rd  out  5 each  latched register numbers, to forwarding unit
  ex_RegDst  out  2  latched destination select
  exRegWr, exMemRead, exMemWr  out  1 each  latched controls, to forwarding unit
  ex_aluop  out  4  latched ALU op
  ex_rdat1, ex_rdat2, ex_imm, ex_pc4  out  WORD_W each  latched data
  lu_stall  out  1  load-use hazard, IF/ID must hold
  bubble_cnt  out  16  saturating count of load-use bubbles
REQ-003 SHALL use CLK as the only clock; nRST asynchronous, active-low.

Function
REQ-004 SHALL register all ex_* outputs and bubble_cnt; lu_stall combinational from current EX registers and id_* inputs.
REQ-005 SHALL compute lu_stall = ex_valid & exMemRead & id_valid & ~flush & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
REQ-006 SHALL select one action per rising edge, priority freeze > flush > lu_stall > load.
REQ-007 freeze=1: all EX registers and bubble_cnt hold; lu_stall still driven per REQ-005.
REQ-008 flush=1 (freeze=0): load bubble; bubble_cnt unchanged.
REQ-009 lu_stall=1 (freeze=0, flush=0): load bubble; bubble_cnt increments by 1, saturating at 16'hFFFF.
REQ-010 load (all three 0): every ex_* register takes its id_* counterpart, ex_valid <= id_valid, one-cycle latency.
REQ-011 Bubble: ex_valid=0, exRegWr=0, exMemRead=0, exMemWr=0, ex_rs=ex_rt=ex_rd=0, ex_RegDst=0, ex_aluop=0; data registers (rdat1, rdat2, imm, pc4) SHALL hold.
REQ-012 Register 0 SHALL never raise lu_stall, even when ex_rt=id_rs=0.
REQ-013 A bubble in EX SHALL deassert lu_stall next cycle, so one load-use yields exactly one bubble absent freeze.
REQ-014 lu_stall held under freeze SHALL produce one bubble, on the first edge with freeze=0.
REQ-015 id_valid=0 with no other condition SHALL load with ex_valid=0 and controls as presented; downstream qualifies on ex_valid.
REQ-016 flush SHALL be acted on only on edges with freeze=0; upstream holds flush until then.

Reset
REQ-017 nRST=0 SHALL immediately clear all ex_* registers and bubble_cnt to 0, regardless of CLK.
REQ-018 During and after reset, until the first load, lu_stall SHALL be 0 (ex_valid=0).
REQ-019 Reset deassertion mid-stream SHALL resume with the first edge after nRST=1, priority per REQ-006.

Verification
REQ-020 Load: id_valid=1, rs=3, rt=4, rd=5, regWr=1, rdat1=0x11 -> next edge ex_valid=1, ex_rd=5, exRegWr=1, ex_rdat1=0x11, lu_stall=0.
REQ-021 Load-use: EX lw rt=8; ID rs=8 -> lu_stall=1; next edge ex_valid=0, exMemRead=0, bubble_cnt=1; lu_stall=0 next cycle, ID then loads.
REQ-022 Freeze: load-use pending, freeze=1 for 3 cycles -> EX and bubble_cnt unchanged; first freeze=0 edge inserts one bubble, bubble_cnt=1.
REQ-023 Flush+hazard: load-use and flush=1 same cycle -> lu_stall=0, bubble inserted, bubble_cnt unchanged.
REQ-024 Zero-reg and saturation: EX lw rt=0, ID rs=0 -> lu_stall=0; bubble_cnt at 16'hFFFF plus another load-use -> stays 16'hFFFF.
REQ-025 Async reset: nRST low between edges with ex_valid=1 -> all outputs 0 before the next CLK edge.
